// File: rtl/reg_file_ctrl_pkg.sv
// Shared definitions for the register-file command controller: FSM state
// encoding, command-byte field positions, datapath widths and the
// reserved-bit mask used by the optional command check.
package reg_file_ctrl_pkg;

  localparam int OPCODE_BIT = 7;   // command bit7: 1 = write, 0 = read
  localparam int DATA_W     = 16;  // register-file word width
  localparam int BYTE_W     = 8;   // stream byte width

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_HI    = 3'd1,
    S_WR_LO    = 3'd2,
    S_WR_ISSUE = 3'd3,
    S_RD_ISSUE = 3'd4,
    S_RD_WAIT  = 3'd5,
    S_RD_HI    = 3'd6,
    S_RD_LO    = 3'd7
  } state_e;

  // Bits between the address field and the opcode bit are reserved.
  function automatic logic [BYTE_W-1:0] reserved_mask(input int addr_width);
    logic [BYTE_W-1:0] m;
    m = '0;
    for (int i = 0; i < OPCODE_BIT; i++) begin
      if (i >= addr_width) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/reg_file_ctrl.sv
// Byte-stream command controller in front of the 8x16 register file.
// Write frame: cmd, data high, data low. Read frame: cmd only; the read word
// is returned high byte first on the output stream.
// Optional macro REG_FILE_CTRL_CMD_CHECK_EN: reject cmd bytes with reserved
// bits set and pulse Err; without it reserved bits are ignored and Err is 0.
module reg_file_ctrl #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            In_Data,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  output logic [7:0]            Out_Data,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [15:0]           WrData,
  input  logic [15:0]           RdData,
  output logic                  Busy,
  output logic                  Err
);

  import reg_file_ctrl_pkg::*;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]       wr_data_q, wr_data_d;
  logic [DATA_W-1:0]       rd_buf_q, rd_buf_d;
  logic                    in_fire, out_fire;
  logic                    cmd_reject;

  assign in_fire  = In_Valid  && In_Ready;
  assign out_fire = Out_Valid && Out_Ready;

`ifdef REG_FILE_CTRL_CMD_CHECK_EN
  localparam logic [BYTE_W-1:0] RSVD_MASK = reserved_mask(ADDR_WIDTH);
  logic err_q, err_d;

  assign cmd_reject = |(In_Data & RSVD_MASK);
  assign err_d      = (state_q == S_IDLE) && in_fire && cmd_reject;

  // One-cycle error pulse in the cycle after a rejected cmd transfer.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign Err = err_q;
`else
  assign cmd_reject = 1'b0;
  assign Err        = 1'b0;
`endif

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wr_data_q <= '0;
      rd_buf_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      rd_buf_q  <= rd_buf_d;
    end
  end

  // Next-state and datapath-capture decode.
  // NOTE: every signal gets a hold-value default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    rd_buf_d  = rd_buf_q;
    case (state_q)
      S_IDLE: begin
        if (in_fire && !cmd_reject) begin
          addr_d  = In_Data[ADDR_WIDTH-1:0];
          state_d = In_Data[OPCODE_BIT] ? S_WR_HI : S_RD_ISSUE;
        end
      end
      S_WR_HI: begin
        if (in_fire) begin
          wr_data_d[DATA_W-1:BYTE_W] = In_Data;
          state_d                    = S_WR_LO;
        end
      end
      S_WR_LO: begin
        if (in_fire) begin
          wr_data_d[BYTE_W-1:0] = In_Data;
          state_d               = S_WR_ISSUE;
        end
      end
      S_WR_ISSUE: state_d = S_IDLE;
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        rd_buf_d = RdData;
        state_d  = S_RD_HI;
      end
      S_RD_HI: if (out_fire) state_d = S_RD_LO;
      S_RD_LO: if (out_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshakes and strobes are pure state decodes; Out_Data only changes on
  // a state change, so it holds while the downstream stalls.
  assign In_Ready  = (state_q == S_IDLE) || (state_q == S_WR_HI) || (state_q == S_WR_LO);
  assign Out_Valid = (state_q == S_RD_HI) || (state_q == S_RD_LO);
  assign Out_Data  = (state_q == S_RD_HI) ? rd_buf_q[DATA_W-1:BYTE_W] :
                     (state_q == S_RD_LO) ? rd_buf_q[BYTE_W-1:0]      : '0;
  assign WrEn      = (state_q == S_WR_ISSUE);
  assign RdEn      = (state_q == S_RD_ISSUE);
  assign Busy      = (state_q != S_IDLE);
  assign Address   = addr_q;
  assign WrData    = wr_data_q;

endmodule

// File: doc/reg_file_ctrl.md
# reg_file_ctrl

Byte-stream command controller that sits directly upstream of the 8×16 register file. It accepts framed commands on an 8-bit valid/ready input stream and drives the register file's `WrEn`/`RdEn`/`Address`/`WrData` pins. It captures the file's `RdData` and returns read results as two bytes on an 8-bit valid/ready output stream. All register-file traffic in the design goes through this block.

## Interface
- `ADDR_WIDTH`, default 3: address width; legal range 1..7.
- `CLK`  in  1  system clock; all logic on the rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `In_Data`  in  8  command/data byte from upstream.
- `In_Valid`  in  1  `In_Data` is valid.
- `In_Ready`  out  1  controller accepts a byte; a transfer occurs on an edge where `In_Valid` and `In_Ready` are both 1.
- `Out_Data`  out  8  read-result byte.
- `Out_Valid`  out  1  `Out_Data` is valid.
- `Out_Ready`  in  1  downstream accepts; a transfer occurs on an edge where `Out_Valid` and `Out_Ready` are both 1.
- `WrEn`  out  1  register-file write strobe.
- `RdEn`  out  1  register-file read strobe.
- `Address`  out  `ADDR_WIDTH`  register-file address.
- `WrData`  out  16  register-file write data.
- `RdData`  in  16  register-file read data; valid from the edge after `RdEn`.
- `Busy`  out  1  1 in every state except IDLE.
- `Err`  out  1  one-cycle frame-error pulse; tied to 0 when the error check is compiled out.

## Operation
- **Command byte:**
  - bit7 = 1 selects write, 0 selects read.
  - bits[`ADDR_WIDTH`-1:0] carry the address.
  - bits[6:`ADDR_WIDTH`] are reserved.
- **Write frame:** cmd, data high byte, data low byte. **Read frame:** cmd only.
- **FSM states:** IDLE, WR_HI, WR_LO, WR_ISSUE, RD_ISSUE, RD_WAIT, RD_HI, RD_LO.
- **Transitions** (each taken on the edge named):
  - IDLE → WR_HI on a write cmd transfer; IDLE → RD_ISSUE on a read cmd transfer. `Address` is latched on the cmd transfer.
  - WR_HI → WR_LO on a byte transfer; the byte is latched to `WrData`[15:8].
  - WR_LO → WR_ISSUE on a byte transfer; the byte is latched to `WrData`[7:0].
  - WR_ISSUE → IDLE unconditionally.
  - RD_ISSUE → RD_WAIT unconditionally.
  - RD_WAIT → RD_HI unconditionally; `RdData` is captured into the internal read buffer.
  - RD_HI → RD_LO on an output transfer; RD_LO → IDLE on an output transfer.
- **Handshake:**
  - `In_Ready` = 1 only in IDLE, WR_HI and WR_LO. It is decoded from the state.
  - `Out_Valid` = 1 only in RD_HI (buffer[15:8]) and RD_LO (buffer[7:0]).
  - `Out_Data` is held stable while `Out_Valid`=1 and `Out_Ready`=0.
  - Gaps in `In_Valid` between bytes of a frame are legal; the FSM holds its state.
- **Strobes:**
  - `WrEn` = 1 exactly in WR_ISSUE; `RdEn` = 1 exactly in RD_ISSUE. They are never both 1.
  - `Address` and `WrData` are stable throughout each strobe cycle.
- **Reset** (asynchronous, at any time, including mid-frame):
  - FSM goes to IDLE and the partial frame is discarded; no strobe is issued.
  - Reset values: `WrEn`=0, `RdEn`=0, `Address`=0, `WrData`=0, `Out_Valid`=0, `Out_Data`=0, `Busy`=0, `Err`=0, read buffer=0, `In_Ready`=1 (IDLE decode).
  - Upstream must not present `In_Valid` while `RST`=0.

## Timing
- Write: `WrEn` is high in the cycle after the low-byte transfer edge. The register file updates at the end of that cycle.
- Read: let E be the cmd transfer edge.
  - `RdEn` is high in cycle E+1.
  - `RdData` is captured at the end of cycle E+2.
  - The high byte is valid from cycle E+3.
  - Minimum frame-to-frame read turnaround is 5 cycles.
- `Err` pulses in the cycle after the offending cmd transfer. The FSM stays in IDLE.
- Back-to-back write frames: the next cmd can transfer one cycle after WR_ISSUE.

## Configuration
- Macro: `REG_FILE_CTRL_CMD_CHECK_EN`.
- **Defined:** a cmd byte with any reserved bit = 1 is rejected.
  - `Err` pulses for one cycle.
  - No state change and no strobe.
- **Undefined:** reserved bits are ignored and `Err` is constant 0.

## Structure
- Shared package `reg_file_ctrl_pkg` holds:
  - the FSM state encoding;
  - constants for opcode bit position (7);
  - data width (16) and byte width (8);
  - the reserved-bit mask derivation.
- Single module, no sub-module; the datapath is too small to warrant splitting.

## Test plan
- **Write:** bytes 0x85, 0xBE, 0xEF → one `WrEn` cycle with `Address`=5 and `WrData`=0xBEEF; `RdEn` stays 0.
- **Read:** model `RdData`=0xBEEF; byte 0x05 → `RdEn` for 1 cycle with `Address`=5; then `Out_Data` 0xBE followed by 0xEF; `Busy` returns to 0.
- **Backpressure:** during a read, hold `Out_Ready`=0 for 5 cycles → `Out_Data` held at 0xBE with `Out_Valid`=1; release → 0xBE then 0xEF.
- **Input gaps:** send 0x83, idle 3 cycles, 0x12, idle 2 cycles, 0x34 → `WrEn` with `Address`=3 and `WrData`=0x1234.
- **Mid-frame reset:** 0x85, 0xBE, then assert `RST` → no `WrEn`; all outputs at reset values; the next frame (0x81, 0x00, 0x01) writes 0x0001 to `Address` 1.
- **Cmd check:**
  - With the macro defined: byte 0x48 → `Err` 1-cycle pulse, no `RdEn`, `In_Ready` stays 1.
  - Without the macro: byte 0x48 → read of `Address` 0, `Err`=0.
